// File: rtl/scale_1d_adv_if.sv
// Control, configuration and output-beat signals of the 1-D nearest-neighbour scale sequencer.
// The master modport is the sequencer side. The slave modport is the consumer/controller side.
interface scale_1d_adv_if #(
    parameter int C_M_WIDTH      = 12,
    parameter int C_S_WIDTH      = 10,
    parameter int C_S_ADDR_WIDTH = 32
);
    logic [C_S_WIDTH-1:0]      s_width;
    logic [C_M_WIDTH-1:0]      m_width;
    logic                      mirror;
    logic                      start;
    logic                      abort;
    logic [C_S_ADDR_WIDTH-1:0] s_base_addr;
    logic [C_S_ADDR_WIDTH-1:0] s_off_addr;
    logic [C_S_ADDR_WIDTH-1:0] s_inc_addr;
    logic                      o_valid;
    logic                      o_ready;
    logic [C_S_WIDTH-1:0]      s_index;
    logic [C_M_WIDTH-1:0]      m_index;
    logic [C_S_ADDR_WIDTH-1:0] s_addr;
    logic                      o_last;
    logic                      busy;
    logic                      done;

    modport master (
        input  s_width, m_width, mirror, start, abort,
               s_base_addr, s_off_addr, s_inc_addr, o_ready,
        output o_valid, s_index, m_index, s_addr, o_last, busy, done
    );

    modport slave (
        output s_width, m_width, mirror, start, abort,
               s_base_addr, s_off_addr, s_inc_addr, o_ready,
        input  o_valid, s_index, m_index, s_addr, o_last, busy, done
    );
endinterface

// File: rtl/scale_1d_adv.sv
// 1-D nearest-neighbour scale sequencer: an accumulator stepper that emits the source index,
// master index and fetch address for each output pixel. It handles upscale, downscale and mirror.
module scale_1d_adv #(
    parameter int C_M_WIDTH      = 12,
    parameter int C_S_WIDTH      = 10,
    parameter int C_S_ADDR_WIDTH = 32
) (
    input  logic           clk,
    input  logic           resetn,
    scale_1d_adv_if.master bus
);
    localparam int ACC_W = C_M_WIDTH + C_S_WIDTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic [ACC_W-1:0]          r_sa, w_sa_nxt;
    logic [ACC_W-1:0]          r_ma, w_ma_nxt;
    logic [C_S_WIDTH-1:0]      r_s_index, w_s_index_nxt;
    logic [C_S_WIDTH-1:0]      r_s_width, w_s_width_nxt;
    logic [C_M_WIDTH-1:0]      r_m_index, w_m_index_nxt;
    logic [C_M_WIDTH-1:0]      r_m_width, w_m_width_nxt;
    logic [C_S_ADDR_WIDTH-1:0] r_s_addr, w_s_addr_nxt;
    logic                      r_mirror, w_mirror_nxt;
    logic                      r_done, w_done_nxt;

    logic w_busy;
    logic w_valid;
    logic w_last;
    logic w_step;
    logic w_src_step;
    logic w_mst_step;
    logic w_zero;

    assign w_busy     = (r_state == ST_RUN);
    assign w_valid    = w_busy && (r_sa >= r_ma);
    assign w_last     = w_valid && (r_m_index == (r_m_width - C_M_WIDTH'(1)));
    assign w_step     = w_busy && (!w_valid || bus.o_ready);
    assign w_src_step = (r_sa <= r_ma);
    assign w_mst_step = (r_sa >= r_ma);
    assign w_zero     = (bus.s_width == '0) || (bus.m_width == '0);

    always_comb begin
        w_state_nxt   = r_state;
        w_sa_nxt      = r_sa;
        w_ma_nxt      = r_ma;
        w_s_index_nxt = r_s_index;
        w_m_index_nxt = r_m_index;
        w_s_addr_nxt  = r_s_addr;
        w_s_width_nxt = r_s_width;
        w_m_width_nxt = r_m_width;
        w_mirror_nxt  = r_mirror;
        w_done_nxt    = 1'b0;

        // Start has priority over abort and over any in-flight beat, so it restarts a busy line silently.
        if (bus.start) begin
            if (w_zero) begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
            end else begin
                w_state_nxt   = ST_RUN;
                w_sa_nxt      = ACC_W'(bus.m_width);
                w_ma_nxt      = ACC_W'(bus.s_width);
                w_s_index_nxt = '0;
                w_m_index_nxt = '0;
                w_s_addr_nxt  = bus.s_base_addr + bus.s_off_addr;
                w_s_width_nxt = bus.s_width;
                w_m_width_nxt = bus.m_width;
                w_mirror_nxt  = bus.mirror;
            end
        end else if (w_busy && bus.abort) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
        end else if (w_step && w_last) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
        end else if (w_step) begin
            // Both comparisons use the pre-step accumulators. When sa == ma, both sides advance together.
            if (w_src_step) begin
                w_sa_nxt      = r_sa + ACC_W'(r_m_width);
                w_s_index_nxt = r_s_index + C_S_WIDTH'(1);
                w_s_addr_nxt  = r_mirror ? (r_s_addr - bus.s_inc_addr)
                                         : (r_s_addr + bus.s_inc_addr);
            end
            if (w_mst_step) begin
                w_ma_nxt      = r_ma + ACC_W'(r_s_width);
                w_m_index_nxt = r_m_index + C_M_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_sa      <= '0;
            r_ma      <= '0;
            r_s_index <= '0;
            r_m_index <= '0;
            r_s_addr  <= '0;
            r_s_width <= '0;
            r_m_width <= '0;
            r_mirror  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sa      <= w_sa_nxt;
            r_ma      <= w_ma_nxt;
            r_s_index <= w_s_index_nxt;
            r_m_index <= w_m_index_nxt;
            r_s_addr  <= w_s_addr_nxt;
            r_s_width <= w_s_width_nxt;
            r_m_width <= w_m_width_nxt;
            r_mirror  <= w_mirror_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign bus.o_valid = w_valid;
    assign bus.o_last  = w_last;
    assign bus.s_index = r_s_index;
    assign bus.m_index = r_m_index;
    assign bus.s_addr  = r_s_addr;
    assign bus.busy    = w_busy;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_scale_1d_adv.sv
// Directed bench for scale_1d_adv: upscale, downscale, mirror with address wrap, backpressure,
// degenerate widths, abort, restart and asynchronous reset mid-line.
module tb_scale_1d_adv;
    localparam int MW = 12;
    localparam int SW = 10;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    scale_1d_adv_if #(.C_M_WIDTH(MW), .C_S_WIDTH(SW), .C_S_ADDR_WIDTH(AW)) bus ();

    scale_1d_adv #(.C_M_WIDTH(MW), .C_S_WIDTH(SW), .C_S_ADDR_WIDTH(AW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [SW-1:0] exp_s [16];
    logic [MW-1:0] exp_m [16];
    logic [AW-1:0] exp_a [16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic start_line(input logic [SW-1:0] sw, input logic [MW-1:0] mw, input logic mir,
                              input logic [AW-1:0] base, input logic [AW-1:0] off,
                              input logic [AW-1:0] inc);
        @(negedge clk);
        bus.s_width     = sw;
        bus.m_width     = mw;
        bus.mirror      = mir;
        bus.s_base_addr = base;
        bus.s_off_addr  = off;
        bus.s_inc_addr  = inc;
        bus.o_ready     = 1'b1;
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start       = 1'b0;
    endtask

    // Entered on the first negedge after start. It leaves on the second negedge after the end-of-line handshake.
    task automatic collect(input int n, input bit bp, output int idle);
        int k   = 0;
        int cyc = 0;
        idle = 0;
        while (k < n && cyc < 300) begin
            bus.o_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            check("busy_run", bus.busy, 1);
            if (bus.o_valid) begin
                check("s_index", bus.s_index, exp_s[k]);
                check("m_index", bus.m_index, exp_m[k]);
                check("s_addr",  bus.s_addr,  exp_a[k]);
                check("o_last",  bus.o_last,  (k == n - 1));
                if (bus.o_ready) k++;
            end else if (bus.busy) begin
                idle++;
            end
            @(negedge clk);
            cyc++;
        end
        check("beats", k, n);
        check("done_end", bus.done, 1);
        check("busy_end", bus.busy, 0);
        check("valid_end", bus.o_valid, 0);
        bus.o_ready = 1'b1;
        @(negedge clk);
        check("done_1cyc", bus.done, 0);
    endtask

    task automatic fill_up();
        for (int i = 0; i < 8; i++) begin
            exp_s[i] = SW'(i / 2);
            exp_m[i] = MW'(i);
            exp_a[i] = 32'h1000 + 32'(4 * (i / 2));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int idle;
        bus.s_width = '0; bus.m_width = '0; bus.mirror = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.o_ready = 1'b1;
        bus.s_base_addr = '0; bus.s_off_addr = '0; bus.s_inc_addr = '0;

        @(negedge clk);
        check("rst_valid", bus.o_valid, 0);
        check("rst_busy",  bus.busy, 0);
        check("rst_done",  bus.done, 0);
        check("rst_last",  bus.o_last, 0);
        check("rst_sidx",  bus.s_index, 0);
        check("rst_midx",  bus.m_index, 0);
        check("rst_addr",  bus.s_addr, 0);
        @(negedge clk);
        resetn = 1'b1;

        // Upscale 4 -> 8: no idle cycles with ready held high
        fill_up();
        start_line(10'd4, 12'd8, 1'b0, 32'h1000, 32'h0, 32'h4);
        collect(8, 1'b0, idle);
        check("up_idle", idle, 0);

        // Downscale 8 -> 4: source 1,3,5,7 with one idle cycle before each beat
        for (int i = 0; i < 4; i++) begin
            exp_s[i] = SW'(2 * i + 1);
            exp_m[i] = MW'(i);
            exp_a[i] = 32'h2010 + 32'(2 * (2 * i + 1));
        end
        start_line(10'd8, 12'd4, 1'b0, 32'h2000, 32'h10, 32'h2);
        collect(4, 1'b0, idle);
        check("dn_idle", idle, 4);

        // Mirror 4 -> 4: addresses decrement from the crop's last pixel
        for (int i = 0; i < 4; i++) begin
            exp_s[i] = SW'(i);
            exp_m[i] = MW'(i);
            exp_a[i] = 32'hC - 32'(4 * i);
        end
        start_line(10'd4, 12'd4, 1'b1, 32'h0, 32'hC, 32'h4);
        collect(4, 1'b0, idle);

        // Upscale under random backpressure: same sequence, held stable while stalled
        fill_up();
        start_line(10'd4, 12'd8, 1'b0, 32'h1000, 32'h0, 32'h4);
        collect(8, 1'b1, idle);

        // m_width = 1: one beat, flagged last, after the source side catches up
        exp_s[0] = 10'd4; exp_m[0] = 12'd0; exp_a[0] = 32'h4;
        start_line(10'd5, 12'd1, 1'b0, 32'h0, 32'h0, 32'h1);
        collect(1, 1'b0, idle);
        check("m1_idle", idle, 4);

        // Zero source width: done only
        start_line(10'd0, 12'd8, 1'b0, 32'h0, 32'h0, 32'h1);
        check("zw_done",  bus.done, 1);
        check("zw_busy",  bus.busy, 0);
        check("zw_valid", bus.o_valid, 0);
        @(negedge clk);
        check("zw_done2", bus.done, 0);

        // Abort after the 3rd beat
        fill_up();
        start_line(10'd4, 12'd8, 1'b0, 32'h1000, 32'h0, 32'h4);
        for (int i = 0; i < 3; i++) begin
            check("ab_valid", bus.o_valid, 1);
            check("ab_sidx",  bus.s_index, exp_s[i]);
            check("ab_midx",  bus.m_index, exp_m[i]);
            @(negedge clk);
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("ab_valid_lo", bus.o_valid, 0);
        check("ab_busy_lo",  bus.busy, 0);
        check("ab_done",     bus.done, 1);
        @(negedge clk);
        check("ab_done2", bus.done, 0);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("ab_idle_done", bus.done, 0);

        // Restart mid-line into mirror mode, with the address wrapping below zero
        start_line(10'd4, 12'd8, 1'b0, 32'h1000, 32'h0, 32'h4);
        @(negedge clk);
        start_line(10'd4, 12'd4, 1'b1, 32'h0, 32'h4, 32'h4);
        check("rs_done", bus.done, 0);
        for (int i = 0; i < 4; i++) begin
            exp_s[i] = SW'(i);
            exp_m[i] = MW'(i);
            exp_a[i] = 32'h4 - 32'(4 * i);
        end
        collect(4, 1'b0, idle);

        // Asynchronous reset mid-line
        start_line(10'd4, 12'd8, 1'b0, 32'h1000, 32'h0, 32'h4);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_addr", bus.s_addr, 32'h1004);
        #2 resetn = 1'b0;
        #1;
        check("ar_valid", bus.o_valid, 0);
        check("ar_busy",  bus.busy, 0);
        check("ar_addr",  bus.s_addr, 0);
        check("ar_midx",  bus.m_index, 0);
        check("ar_sidx",  bus.s_index, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("ar_done", bus.done, 0);
        check("ar_idle", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/scale_1d_adv.md
Name: scale_1d_adv

Overview:
- Next-generation 1-D nearest-neighbour scale sequencer for the mm2s_adv datapath.
- For each output (master) pixel of a line, it emits the source (slave) pixel index, the master index and the source fetch address.
- It uses an accumulator (Bresenham-style) stepper and covers both up- and downscale.
- New over the previous generation: mirror (address decrement) mode, abort, combinational last flag, done/busy status, and defined handling of zero-width and restart cases.

Parameters:
- C_M_WIDTH, 12, bit width of master (output) width and index.
- C_S_WIDTH, 10, bit width of source width and index.
- C_S_ADDR_WIDTH, 32, source address width.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- s_width  in  C_S_WIDTH  source pixels per line; sampled on start.
- m_width  in  C_M_WIDTH  output pixels per line; sampled on start.
- mirror  in  1  sampled on start; 1 = address decrements per source step.
- start  in  1  one-cycle pulse that begins a line.
- abort  in  1  one-cycle pulse that terminates the current line.
- s_base_addr  in  C_S_ADDR_WIDTH  line base address.
- s_off_addr  in  C_S_ADDR_WIDTH  offset of first fetched pixel (the last pixel of the crop when mirror=1).
- s_inc_addr  in  C_S_ADDR_WIDTH  bytes per source pixel.
- o_valid  out  1  output beat valid.
- o_ready  in  1  downstream ready.
- s_index  out  C_S_WIDTH  source index of current beat.
- m_index  out  C_M_WIDTH  master index of current beat.
- s_addr  out  C_S_ADDR_WIDTH  fetch address for s_index.
- o_last  out  1  current beat is the last of the line.
- busy  out  1  line in progress.
- done  out  1  one-cycle pulse at line end.

Behaviour:
- Clock and reset: single clock clk; resetn is asynchronous, active-low. All registers clear to 0, so busy=0, o_valid=0, o_last=0, done=0, and s_index, m_index, s_addr = 0.
- Widths: accumulators sa and ma are C_M_WIDTH+C_S_WIDTH bits and never overflow within one line. m_width and s_width are latched internally at start.
- Start, valid widths (start=1, both widths nonzero):
  - Next cycle: busy=1, sa=m_width, ma=s_width, s_index=0, m_index=0, s_addr=s_base_addr+s_off_addr.
  - Widths and mirror are latched.
- Start, zero width (start=1, either width 0): no beats are emitted; busy stays 0; done pulses next cycle.
- Validity: o_valid = busy && (sa >= ma), combinational from registers.
- Step condition: step = busy && (!o_valid || o_ready). On a step, both comparisons use pre-step values:
  - If sa <= ma: sa += m_width; s_index += 1; s_addr += s_inc_addr, or -= s_inc_addr when mirror latched.
  - If sa >= ma: ma += s_width; m_index += 1.
  - Both branches may fire in the same cycle.
- Handshake: o_valid, once high, holds with s_index, m_index and s_addr stable until o_ready.
- o_last = o_valid && (m_index == m_width_latched - 1). It is combinational, so m_width=1 gives o_last on the first beat.
- End of line: on the handshake with o_last=1, busy clears next cycle, done pulses for one cycle, and o_valid drops.
- Beat count: exactly m_width beats per line.
  - Upscale repeats source indices.
  - Downscale skips source indices; non-valid cycles advance sa without stalling on o_ready.
- Restart: start while busy restarts immediately with the new parameters; no done pulse for the dropped line.
- Abort: abort while busy clears busy and o_valid next cycle and pulses done. Abort is ignored when idle. Simultaneous start and abort: start wins.
- Reset mid-line returns to idle asynchronously; no done pulse.
- Address arithmetic is modulo 2^C_S_ADDR_WIDTH.

Test Plan:
- Upscale: s_width=4, m_width=8, base=0x1000, off=0, inc=4, o_ready=1 -> 8 beats; s_index 0,0,1,1,2,2,3,3; m_index 0..7; s_addr 0x1000,0x1000,0x1004,…,0x100C; o_last only on m_index=7; done one cycle after.
- Downscale: s_width=8, m_width=4, o_ready=1 -> s_index 1,3,5,7; m_index 0..3; idle cycles between beats.
- Mirror: s_width=4, m_width=4, off=0xC, inc=4, mirror=1 -> s_addr 0xC,0x8,0x4,0x0; s_index 0..3.
- Backpressure: upscale case with o_ready toggling 1/0 pseudo-randomly -> identical beat sequence; outputs stable while o_valid && !o_ready.
- Degenerate: m_width=1, s_width=5 -> single beat with o_last=1; s_width=0 -> no o_valid, done pulse the cycle after start.
- Abort/restart/reset: abort after 3rd beat -> o_valid low next cycle, done pulse; start mid-line -> sequence restarts at index 0 with no done; resetn low mid-line -> outputs 0 immediately.
